// File: rtl/pet_life_if.sv
// rtl/pet_life_if.sv - control/status bundle between the tamagotchi core and pet_life_ctrl
interface pet_life_if;
    logic       ena;
    logic       btn_feed;
    logic       btn_play;
    logic       btn_sleep;
    logic [2:0] state;
    logic [3:0] hunger;
    logic [3:0] happy;
    logic       alive;
    logic       tick;

    modport master (
        output ena, btn_feed, btn_play, btn_sleep,
        input  state, hunger, happy, alive, tick
    );

    modport slave (
        input  ena, btn_feed, btn_play, btn_sleep,
        output state, hunger, happy, alive, tick
    );
endinterface

// File: rtl/pet_life_ctrl.sv
// rtl/pet_life_ctrl.sv - game-tick prescaler, button debouncing and pet life-cycle state machine
module pet_life_ctrl #(
    parameter int TICK_DIV     = 1000,
    parameter int ACTION_TICKS = 4,
    parameter int SICK_LIMIT   = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    pet_life_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EAT   = 3'd1,
        S_PLAY  = 3'd2,
        S_SLEEP = 3'd3,
        S_SICK  = 3'd4,
        S_DEAD  = 3'd5
    } state_t;

    localparam int CW = $clog2(TICK_DIV);
    localparam int AW = $clog2(2 * ACTION_TICKS + 1);
    localparam int SW = $clog2(SICK_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre_cnt;
    logic          tick_q;
    logic [2:0]    sync1, sync2, prev;
    logic [2:0]    press;

    state_t        state_q, state_d;
    logic [3:0]    hunger_q, hunger_d, happy_q, happy_d;
    logic [AW-1:0] act_q, act_d;
    logic [SW-1:0] sick_q, sick_d;
    logic          alive_q;

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] d);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, d};
        return s[4] ? 4'hF : s[3:0];
    endfunction

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] d);
        return (a < d) ? 4'h0 : a - d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            if (bus.ena) pre_cnt <= (pre_cnt == CNT_MAX) ? '0 : pre_cnt + CW'(1);
            tick_q <= bus.ena && (pre_cnt == CNT_MAX);
        end
    end

    // bit 0 feed, bit 1 play, bit 2 sleep; prev holds sync2 one cycle back for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {bus.btn_sleep, bus.btn_play, bus.btn_feed};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev & {3{bus.ena}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hunger_q <= 4'd4;
            happy_q  <= 4'd12;
            act_q    <= '0;
            sick_q   <= '0;
            alive_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            hunger_q <= hunger_d;
            happy_q  <= happy_d;
            act_q    <= act_d;
            sick_q   <= sick_d;
            alive_q  <= (state_d != S_DEAD);
        end
    end

    always_comb begin
        state_d  = state_q;
        hunger_d = hunger_q;
        happy_d  = happy_q;
        act_d    = act_q;
        sick_d   = sick_q;
        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    hunger_d = sat_add(hunger_q, 4'd1);
                    happy_d  = sat_sub(happy_q, 4'd1);
                end
                if (press[0]) begin
                    state_d = S_EAT;
                    act_d   = AW'(ACTION_TICKS);
                end else if (press[1]) begin
                    state_d = S_PLAY;
                    act_d   = AW'(ACTION_TICKS);
                end else if (press[2]) begin
                    state_d = S_SLEEP;
                    act_d   = AW'(2 * ACTION_TICKS);
                end else if (hunger_d == 4'hF || happy_d == 4'h0) begin
                    state_d = S_SICK;
                    sick_d  = '0;
                end
            end
            S_EAT: begin
                if (tick_q) begin
                    hunger_d = sat_sub(hunger_q, 4'd2);
                    act_d    = act_q - AW'(1);
                    if (act_d == '0) state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (tick_q) begin
                    happy_d  = sat_add(happy_q, 4'd2);
                    hunger_d = sat_add(hunger_q, 4'd1);
                    act_d    = act_q - AW'(1);
                    if (act_d == '0) state_d = S_IDLE;
                end
            end
            S_SLEEP: begin
                if (|press) begin
                    state_d = S_IDLE;
                end else if (tick_q) begin
                    act_d = act_q - AW'(1);
                    if (act_d == '0) state_d = S_IDLE;
                end
            end
            S_SICK: begin
                // a feed landing on the fatal tick still rescues the pet
                if (press[0]) begin
                    state_d  = S_IDLE;
                    sick_d   = '0;
                    hunger_d = (hunger_q > 4'd7) ? 4'd7 : hunger_q;
                    happy_d  = (happy_q < 4'd4) ? 4'd4 : happy_q;
                end else if (tick_q) begin
                    sick_d = sick_q + SW'(1);
                    if (sick_d == SW'(SICK_LIMIT)) state_d = S_DEAD;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.state  = state_q;
        bus.hunger = hunger_q;
        bus.happy  = happy_q;
        bus.alive  = alive_q;
        bus.tick   = tick_q;
    end
endmodule

// File: tb/tb_pet_life_ctrl.sv
// tb/tb_pet_life_ctrl.sv - randomized and directed check of pet_life_ctrl against a behavioural model
module tb_pet_life_ctrl;
    localparam int TD = 4;
    localparam int AT = 2;
    localparam int SL = 3;

    logic clk = 1'b0;
    logic rst_n;
    pet_life_if bus();

    pet_life_ctrl #(.TICK_DIV(TD), .ACTION_TICKS(AT), .SICK_LIMIT(SL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    // model: life state as plain integers, button history as raw samples per edge
    int m_state, m_h, m_p, m_ac, m_sc, en_cnt;
    bit m_tick;
    bit hist [3][3];

    function automatic int clamp(int v);
        return (v < 0) ? 0 : ((v > 15) ? 15 : v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_h = 4; m_p = 12; m_ac = 0; m_sc = 0;
        en_cnt = 0; m_tick = 0;
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < 3; a++) hist[b][a] = 0;
    endtask

    task automatic model_step();
        bit ev [3];
        bit raw [3];
        bit t;
        raw[0] = bus.btn_feed; raw[1] = bus.btn_play; raw[2] = bus.btn_sleep;
        // a press registers three edges after the raw rise: sampled high two edges ago, low three ago
        for (int b = 0; b < 3; b++) ev[b] = bus.ena && hist[b][1] && !hist[b][2];
        t = m_tick;
        case (m_state)
            0: begin
                if (t) begin m_h = clamp(m_h + 1); m_p = clamp(m_p - 1); end
                if (ev[0]) begin m_state = 1; m_ac = AT; end
                else if (ev[1]) begin m_state = 2; m_ac = AT; end
                else if (ev[2]) begin m_state = 3; m_ac = 2 * AT; end
                else if (m_h == 15 || m_p == 0) begin m_state = 4; m_sc = 0; end
            end
            1: if (t) begin
                m_h = clamp(m_h - 2); m_ac--;
                if (m_ac == 0) m_state = 0;
            end
            2: if (t) begin
                m_p = clamp(m_p + 2); m_h = clamp(m_h + 1); m_ac--;
                if (m_ac == 0) m_state = 0;
            end
            3: begin
                if (ev[0] || ev[1] || ev[2]) m_state = 0;
                else if (t) begin
                    m_ac--;
                    if (m_ac == 0) m_state = 0;
                end
            end
            4: begin
                if (ev[0]) begin
                    m_state = 0; m_sc = 0;
                    if (m_h > 7) m_h = 7;
                    if (m_p < 4) m_p = 4;
                end else if (t) begin
                    m_sc++;
                    if (m_sc == SL) m_state = 5;
                end
            end
            default: ;
        endcase
        for (int b = 0; b < 3; b++) begin
            hist[b][2] = hist[b][1];
            hist[b][1] = hist[b][0];
            hist[b][0] = raw[b];
        end
        if (bus.ena) en_cnt++;
        m_tick = bus.ena && (en_cnt % TD == 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", bus.state, m_state);
            check("hunger", bus.hunger, m_h);
            check("happy", bus.happy, m_p);
            check("alive", bus.alive, (m_state != 5) ? 1 : 0);
            check("tick", bus.tick, m_tick);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
        end
    endtask

    task automatic set_btn(input bit f, input bit p, input bit s);
        bus.btn_feed = f; bus.btn_play = p; bus.btn_sleep = s;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        set_btn(0, 0, 0);
        bus.ena = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pin(input string name, input int exp_state, input int exp_h, input int exp_p);
        check({name, "_state"}, bus.state, exp_state);
        check({name, "_hunger"}, bus.hunger, exp_h);
        check({name, "_happy"}, bus.happy, exp_p);
        check({name, "_model_state"}, 32'(m_state), exp_state);
        check({name, "_model_hunger"}, 32'(m_h), exp_h);
        check({name, "_model_happy"}, 32'(m_p), exp_p);
    endtask

    initial begin
        int nticks;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        set_btn(0, 0, 0);
        model_reset();
        chk_en = 1;
        cyc(2);
        rst_n = 1'b1;
        pin("reset", 0, 4, 12);
        check("reset_alive", bus.alive, 1);
        check("reset_tick", bus.tick, 0);

        // neglect: 11 ticks saturate hunger and drive into SICK, 3 more ticks kill
        cyc(45);
        pin("neglect", 4, 15, 1);
        cyc(12);
        pin("dead", 5, 15, 1);
        check("dead_alive", bus.alive, 0);
        set_btn(1, 1, 1);
        cyc(3);
        set_btn(0, 0, 0);
        cyc(10);
        pin("dead_frozen", 5, 15, 1);

        do_reset();
        pin("rst_after_dead", 0, 4, 12);
        set_btn(1, 0, 0);
        cyc(3);
        pin("feed_entry", 1, 4, 12);
        set_btn(0, 0, 0);
        cyc(6);
        pin("feed_done", 0, 0, 12);

        do_reset();
        set_btn(1, 1, 0);
        cyc(3);
        pin("feed_play_prio", 1, 4, 12);
        set_btn(0, 0, 0);
        cyc(1);
        set_btn(0, 1, 0);
        cyc(3);
        pin("play_in_eat", 1, 2, 12);
        set_btn(0, 0, 0);
        cyc(2);
        pin("eat_exit", 0, 0, 12);

        do_reset();
        set_btn(0, 0, 1);
        cyc(2);
        set_btn(0, 0, 0);
        cyc(1);
        pin("sleep_entry", 3, 4, 12);
        cyc(2);
        set_btn(0, 1, 0);
        cyc(3);
        pin("sleep_wake", 0, 4, 12);
        set_btn(0, 0, 0);
        cyc(2);
        pin("no_play_after_wake", 0, 5, 11);

        do_reset();
        cyc(45);
        set_btn(1, 0, 0);
        cyc(3);
        set_btn(0, 0, 0);
        pin("sick_feed", 0, 7, 4);

        do_reset();
        cyc(54);
        set_btn(1, 0, 0);
        cyc(3);
        set_btn(0, 0, 0);
        pin("fatal_tick_feed", 0, 7, 4);

        bus.ena = 1'b0;
        nticks = 0;
        for (int i = 0; i < 20; i++) begin
            set_btn(i < 5, i >= 8 && i < 12, 0);
            cyc(1);
            if (bus.tick) nticks++;
        end
        check("ena_low_ticks", 32'(nticks), 0);
        pin("ena_low_hold", 0, 7, 4);
        bus.ena = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            bus.ena = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 5) == 0) bus.btn_feed = ~bus.btn_feed;
            if ($urandom_range(0, 7) == 0) bus.btn_play = ~bus.btn_play;
            if ($urandom_range(0, 9) == 0) bus.btn_sleep = ~bus.btn_sleep;
            cyc(1);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pet_life_ctrl.md
Name: pet_life_ctrl

Overview:
Central life-cycle controller for the tamagotchi core. It divides clk into game ticks and debounces the three user buttons into single-cycle press events. It runs the pet state machine (idle/eat/play/sleep/sick/dead) and maintains saturating hunger and happiness counters. Its outputs drive the uo_out status byte and the display logic.

Parameters:
TICK_DIV, 1000, clk cycles per game tick (>=2)
ACTION_TICKS, 4, ticks spent in EAT or PLAY; SLEEP lasts 2*ACTION_TICKS
SICK_LIMIT, 8, ticks in SICK before DEAD

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low freezes prescaler and ignores presses
btn_feed  in  1  raw feed button (async)
btn_play  in  1  raw play button (async)
btn_sleep  in  1  raw sleep button (async)
state  out  3  IDLE=0 EAT=1 PLAY=2 SLEEP=3 SICK=4 DEAD=5
hunger  out  4  0 = full, 15 = starving
happy  out  4  0 = miserable, 15 = ecstatic
alive  out  1  0 only in DEAD
tick  out  1  one-cycle pulse per game tick

Behaviour:
- One clock, clk; asynchronous active-low reset rst_n. All state is registered.
- Reset values: state=IDLE, hunger=4, happy=12, alive=1, tick=0, prescaler=0, action_cnt=0, sick_cnt=0, synchronisers and edge flops=0.
- Prescaler: counts 0..TICK_DIV-1 while ena=1 and holds while ena=0. tick=1 for the single cycle in which the count wraps to 0.
- Buttons: 2-flop synchroniser, then rising-edge detect. A press event is a 1-cycle pulse, 3 clk after the raw rise. Events are discarded while ena=0.
- Priority on simultaneous presses: feed > play > sleep; lower-priority events that cycle are dropped.
- Arithmetic: all stat updates saturate at 0 and 15; no wrap-around.
- IDLE:
  - on tick, hunger+1 and happy-1.
  - feed -> EAT, play -> PLAY, each with action_cnt=ACTION_TICKS; sleep -> SLEEP with action_cnt=2*ACTION_TICKS.
  - with no press that cycle, if the post-update hunger==15 or happy==0 -> SICK with sick_cnt=0.
  - tick and press in the same cycle: tick update applies, press transition wins, sick check is skipped.
- EAT: on tick, hunger-2 and action_cnt-1; when action_cnt reaches 0 -> IDLE. Presses are ignored.
- PLAY: on tick, happy+2, hunger+1 and action_cnt-1; when action_cnt reaches 0 -> IDLE. Presses are ignored. Hunger may reach 15 here; the sick check runs on return to IDLE.
- SLEEP: stats frozen. On tick, action_cnt-1; at 0 -> IDLE. Any press -> IDLE immediately; the press is consumed and not re-evaluated in IDLE.
- SICK:
  - stats frozen; on tick, sick_cnt+1.
  - when sick_cnt reaches SICK_LIMIT -> DEAD.
  - feed press -> IDLE, sick_cnt=0, hunger=min(hunger,7), happy=max(happy,4). Other presses are ignored.
  - a feed press in the same cycle as the fatal tick takes precedence: the pet survives.
- DEAD: alive=0; all registers frozen and presses ignored; leaves DEAD only via rst_n.
- Reset mid-operation: rst_n low returns every register to its reset value asynchronously, including a press in flight in the synchroniser.
- state, hunger, happy and alive are direct register outputs with no combinational path from inputs.

Test Plan:
(Sim parameters: TICK_DIV=4, ACTION_TICKS=2, SICK_LIMIT=3.)
- Reset then idle, no presses, 11 ticks -> hunger saturates at 15, happy 12->1; on tick 11 hunger=15, so state=SICK.
- From reset, pulse btn_feed -> state=EAT 3 clk later; after 2 ticks hunger 4 (or 5, if a tick landed before entry) -> 0 saturated, then state=IDLE.
- From reset, btn_feed and btn_play rise in the same clk -> EAT only. Then press play while in EAT -> ignored; state=EAT until action_cnt=0.
- Sleep press then btn_play press after 1 tick -> SLEEP exits to IDLE on the press, stats unchanged during SLEEP, no PLAY entry.
- Drive to SICK and hold for 3 ticks -> state=DEAD, alive=0. Further presses and ticks leave all outputs unchanged; rst_n pulse -> IDLE, hunger=4, happy=12.
- In SICK with hunger=15, happy=9: feed press -> IDLE, hunger=7, happy=9. Repeat with the feed press aligned to the fatal tick -> IDLE, not DEAD. Hold ena=0 for 20 clk -> no tick pulses, presses ignored.
